// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit layout.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Offsets are selected by addr[2] inside the 8-byte window.
  localparam logic TXDATA_OFS = 1'b0;
  localparam logic STATUS_OFS = 1'b1;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 8;

  function automatic logic [31:0] pack_status(
    input logic                    full,
    input logic                    empty,
    input logic                    busy,
    input logic                    ovf,
    input logic [STAT_COUNT_W-1:0] count
  );
    logic [31:0] s;
    s = 32'h0000_0000;
    s[STAT_FULL_BIT]  = full;
    s[STAT_EMPTY_BIT] = empty;
    s[STAT_BUSY_BIT]  = busy;
    s[STAT_OVF_BIT]   = ovf;
    s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is taken
// only when a pop frees the head slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push_s, do_pop_s;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Accept/advance decisions; the head is read before any same-edge overwrite.
  always_comb begin
    do_pop_s  = pop_i && !empty_o;
    do_push_s = push_i && (!full_o || do_pop_s);
    if (do_push_s) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: decodes stores to an 8-byte window,
// queues bytes in a FIFO and shifts them out LSB first on tx.
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t         state_q, state_d;
  logic [CW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;

  logic              sel_s, push_s, ovf_clr_s, pop_s, baud_last_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [7:0]        fifo_rdata_s;
  logic [FCW-1:0]    fifo_count_s;
  logic              unused_bits_s;

  assign sel_s       = (addr[31:3] == BASE_ADDR[31:3]);
  assign push_s      = we && sel_s && (addr[2] == TXDATA_OFS);
  assign ovf_clr_s   = we && sel_s && (addr[2] == STATUS_OFS) && wdata[STAT_OVF_BIT];
  assign baud_last_s = (baud_q == BAUD_LAST);
  assign unused_bits_s = ^{addr[1:0], wdata[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .wdata_i (wdata[7:0]),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Frame sequencer: baud counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + {{(CW-1){1'b0}}, 1'b1};
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_rdata_s;
          tx_d    = 1'b0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_last_s) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_last_s) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (baud_last_s) begin
          baud_d = '0;
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_rdata_s;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Overflow is sticky: set when a store is refused, cleared by software.
  always_comb begin
    if (push_s && fifo_full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE) || !fifo_empty_s;

  // Combinational load path, matching the data memory's read timing.
  always_comb begin
    rdata = 32'h0000_0000;
    if (re && sel_s && (addr[2] == STATUS_OFS)) begin
      rdata = pack_status(fifo_full_s, fifo_empty_s, busy, ovf_q,
                          STAT_COUNT_W'(fifo_count_s));
    end else begin
      rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised bench: a frame-schedule model predicts the line and STATUS, and a
// line decoder checks received bytes against the accepted-byte scoreboard.
module tb_mmio_uart_tx;

  localparam int          C    = 4;
  localparam int          D    = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata;
  logic        tx, busy;

  always #5 clk = ~clk;

  mmio_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx(tx), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending bytes plus the start edge of the frame on the line.
  int         cyc = 0;
  logic [7:0] mq[$];
  bit         act = 1'b0;
  int         fstart = 0;
  logic [7:0] fbyte = 8'h00;
  bit         movf = 1'b0;
  logic [7:0] exp_q[$];
  int         exp_flush = 0;
  int         exp_rd = 0;
  string      rx_str = "";

  always @(posedge clk) begin : model
    bit sel, push, pop, ok;
    if (rst) begin
      mq.delete();
      act = 1'b0;
      movf = 1'b0;
      exp_flush = exp_q.size();
    end else begin
      cyc++;
      sel  = (addr[31:3] == BASE[31:3]);
      push = we && sel && !addr[2];
      pop  = (mq.size() > 0) && (!act || cyc == fstart + 10*C);
      ok   = push && (mq.size() < D || pop);
      if (pop) begin
        fbyte = mq.pop_front();
        fstart = cyc;
        act = 1'b1;
      end else if (act && cyc == fstart + 10*C) begin
        act = 1'b0;
      end
      if (ok) begin
        mq.push_back(wdata[7:0]);
        exp_q.push_back(wdata[7:0]);
      end
      if (push && !ok) movf = 1'b1;
      else if (we && sel && addr[2] && wdata[3]) movf = 1'b0;
    end
  end

  function automatic logic exp_busy();
    if (rst) return 1'b0;
    return act || (mq.size() != 0);
  endfunction

  function automatic logic exp_tx();
    int k;
    if (rst || !act) return 1'b1;
    k = (cyc - fstart) / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return fbyte[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'h0;
    s[15:8] = 8'(mq.size());
    s[3] = movf;
    s[2] = exp_busy();
    s[1] = (mq.size() == 0);
    s[0] = (mq.size() == D);
    return s;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a, input bit r);
    if (!r || a[31:3] != BASE[31:3] || !a[2]) return 32'h0;
    return exp_status();
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic drive(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d;
    #1;
    if (r) chk("rdata", rdata, exp_rdata(a, r));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      we = 1'b0; re = 1'b0;
    end
  endtask

  task automatic wait_idle(input int maxc, output int hi);
    bit done;
    done = 1'b0;
    hi = 0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk);
      we = 1'b0; re = 1'b0;
      if (busy) hi++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL busy_timeout got=1 want=0");
    end
  endtask

  initial begin
    int hi;
    int toggles;
    bit hit;
    int op;
    logic [31:0] a, d;

    fork
      forever begin : line_check
        @(negedge clk);
        if (rst) begin
          chk("tx_in_reset", tx, 1'b1);
          chk("busy_in_reset", busy, 1'b0);
        end else begin
          chk("tx_line", tx, exp_tx());
          chk("busy", busy, exp_busy());
        end
      end
      begin : decoder
        bit dact;
        int dcnt;
        logic [7:0] dbyte;
        dact = 1'b0; dcnt = 0; dbyte = 8'h00;
        forever begin
          @(negedge clk);
          if (rst) begin
            dact = 1'b0;
            exp_rd = exp_flush;
          end else if (!dact) begin
            if (tx === 1'b0) begin dact = 1'b1; dcnt = 0; end
          end else begin
            dcnt++;
            if (dcnt >= C && dcnt < 9*C && dcnt % C == C/2) dbyte[dcnt/C - 1] = tx;
            if (dcnt == 9*C + C/2) begin
              chk("stop_bit", tx, 1'b1);
              if (exp_rd < exp_q.size()) begin
                chk("rx_byte", dbyte, exp_q[exp_rd]);
                exp_rd++;
              end else begin
                checks++; errors++;
                $display("FAIL rx_unexpected got=%h want=none", dbyte);
              end
              rx_str = $sformatf("%s%c", rx_str, dbyte);
              dact = 1'b0;
            end
          end
        end
      end
    join_none

    // Power-on reset
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    drive(0, 1, BASE + 32'd4, 32'h0);
    chk("status_after_reset", rdata, 32'h0000_0002);

    // Single byte: 10 bit periods plus the pop edge
    drive(1, 0, BASE, 32'h55);
    wait_idle(20*C, hi);
    chk("single_busy_len", hi, 10*C + 1);

    // Back-to-back frames, measured from the third store
    rx_str = "";
    drive(1, 0, BASE, 32'h41);
    drive(1, 0, BASE, 32'h42);
    drive(1, 0, BASE, 32'h43);
    wait_idle(40*C, hi);
    chk("b2b_busy_len", hi, 30*C - 1);
    checks++;
    if (rx_str != "ABC") begin
      errors++;
      $display("FAIL b2b_string got=%s want=ABC", rx_str);
    end

    // Overflow mid-frame: 8 fit, the 9th is dropped
    drive(1, 0, BASE, 32'h11);
    idle(2*C);
    for (int i = 0; i < 9; i++) drive(1, 0, BASE, 32'h60 + i);
    drive(0, 1, BASE + 32'd4, 32'h0);
    chk("ovf_status", rdata, 32'h0000_080D);
    drive(1, 0, BASE + 32'd4, 32'h8);
    drive(0, 1, BASE + 32'd4, 32'h0);
    chk("ovf_cleared", rdata, 32'h0000_0805);

    // Store landing on the STOP-end pop edge while full
    hit = 1'b0;
    for (int i = 0; i < 20*C && !hit; i++) begin
      @(negedge clk);
      we = 1'b0; re = 1'b0;
      if (cyc + 1 == fstart + 10*C) hit = 1'b1;
    end
    chk("pop_edge_found", hit, 1'b1);
    we = 1'b1; addr = BASE; wdata = 32'h7E;
    drive(0, 1, BASE + 32'd4, 32'h0);
    chk("full_pop_status", rdata, 32'h0000_0805);
    wait_idle(12*10*C, hi);

    // Decode window and ignored low address bits
    drive(1, 0, BASE + 32'd8, 32'h77);
    drive(0, 1, BASE - 32'd4, 32'h0);
    chk("below_window_rdata", rdata, 32'h0);
    drive(0, 1, BASE + 32'd4, 32'h0);
    chk("no_push_outside", rdata, 32'h0000_0002);
    drive(1, 0, BASE + 32'd2, 32'h31);
    drive(1, 0, BASE + 32'd1, 32'h32);
    drive(0, 1, BASE + 32'd7, 32'h0);
    chk("status_count", rdata[15:8], 32'd1);
    drive(0, 0, BASE + 32'd4, 32'h0);
    #1 chk("re_low_rdata", rdata, 32'h0);
    drive(1, 1, BASE + 32'd4, 32'h0);
    wait_idle(4*10*C, hi);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      d  = $urandom;
      a  = BASE | ($urandom & 32'h3);
      case (op)
        0, 1, 2: drive(1, 1'($urandom_range(0, 1)), a, d);
        3:       drive(1, 1'($urandom_range(0, 1)), a | 32'h4, d);
        4, 5:    drive(0, 1, a | 32'h4, d);
        6: begin
          a = $urandom;
          if (a[31:3] == BASE[31:3]) a[31] = ~a[31];
          drive(1'($urandom_range(0, 1)), 1, a, d);
        end
        7:       drive(0, 1, a, d);
        default: drive(0, 0, a, d);
      endcase
    end
    wait_idle((D + 2)*10*C, hi);

    // Reset in the middle of a start bit
    drive(1, 0, BASE, 32'hA5);
    idle(2);
    chk("pre_reset_tx", tx, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("reset_tx_async", tx, 1'b1);
    chk("reset_busy_async", busy, 1'b0);
    chk("reset_rdata", rdata, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    drive(0, 1, BASE + 32'd4, 32'h0);
    chk("status_after_midframe_reset", rdata, 32'h0000_0002);
    toggles = 0;
    for (int i = 0; i < 12*C; i++) begin
      @(negedge clk);
      we = 1'b0; re = 1'b0;
      if (tx !== 1'b1) toggles++;
    end
    chk("quiet_after_reset", toggles, 0);

    chk("all_bytes_received", exp_rd, exp_q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter, the device-side responder to the pipeline's store traffic. Sits on the data-memory bus beside `PipelineTop`'s data memory and decodes stores to its window. Buffers bytes in a small FIFO and serialises them 8N1, LSB first, on a single `tx` line. Benches use it as the program's console output and decode the line back into characters.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; ≥ 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥ 2.
- `BASE_ADDR`, 32'h1000_0000: word-aligned base of the 8-byte register window.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `we` in 1: store strobe from the pipeline memory stage.
- `re` in 1: load strobe.
- `addr` in 32: byte address; only `addr[31:3] == BASE_ADDR[31:3]` selects the block.
- `wdata` in 32: store data.
- `rdata` out 32: load data; combinational; 0 when not selected or `re` is low.
- `tx` out 1: serial line, registered, idle high.
- `busy` out 1: high while a frame is on the line or the FIFO is non-empty.

## Operation
- Register map (offset = `addr[2]`):
  - **0x0 TXDATA.** A write pushes `wdata[7:0]`. A read returns 0.
  - **0x4 STATUS.** Read returns `{count[..], 0…, ovf, busy, empty, full}`, with `full`=bit0, `empty`=bit1, `busy`=bit2, `ovf`=bit3, and `count` in bits[15:8].
  - Writing STATUS with `wdata[3]`=1 clears `ovf`. Other STATUS bits are read-only.
- A write to TXDATA while the FIFO is full and no pop occurs that cycle:
  - the byte is dropped;
  - `ovf` is set (sticky).
- Simultaneous push and pop is always accepted, including when the FIFO is full. `count` is unchanged.
- `addr[1:0]` is ignored. `we` and `re` in the same cycle are legal and independent.
- FSM states: IDLE, START, DATA, STOP.
  - **IDLE:** if FIFO non-empty at an edge → pop into shift reg, `tx`←0, go START.
  - **START:** hold for `CLKS_PER_BIT` cycles → `tx`←shift[0], bit index←0, go DATA.
  - **DATA:** each bit is held `CLKS_PER_BIT` cycles, then shift right. After bit 7 → `tx`←1, go STOP.
  - **STOP:** hold for `CLKS_PER_BIT` cycles. On the last cycle:
    - if FIFO non-empty → pop, `tx`←0, go START (no idle gap);
    - else → go IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1 and resets on every state change. Bit index is 3 bits and does not wrap past 7.
- Reset, including mid-frame:
  - `tx`=1 immediately, `busy`=0, `rdata`=0 (no access);
  - FIFO empty, `count`=0, `ovf`=0, state IDLE, counters 0;
  - a partially sent frame is abandoned, not completed.

## Timing
- `rdata` is valid in the same cycle as `re`/`addr`, matching the data memory's combinational read.
- Store at edge N with FIFO empty and FSM in IDLE:
  - byte enters the FIFO at N;
  - popped at N+1; `tx` falls after N+1;
  - first data bit appears after edge N+1+`CLKS_PER_BIT`.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles from the start-bit edge to the next possible start-bit edge.
- `busy` is registered-state derived. It rises the cycle after the first push and falls after the last stop bit completes.
- `count` reflects pushes and pops of the previous edge.

## Structure
- Package `uart_tx_pkg` holds:
  - the FSM state enum `tx_state_t`;
  - register offsets `TXDATA_OFS`, `STATUS_OFS`;
  - STATUS bit-position constants.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): push, pop, full, empty, count.
  - Pointers carry one extra wrap bit.
  - Push-when-full is refused internally unless a pop occurs in the same cycle.
- Top level contains the address decode, `ovf` register, FSM, baud/bit counters and shift register.

## Test plan
- **Reset:** assert `rst` mid-frame → `tx`=1 in the same cycle, STATUS reads 32'h0000_0002, no further toggles after release.
- **Single byte:** `CLKS_PER_BIT`=4, store 0x55 to TXDATA → `tx` pattern 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; `busy` low 41 cycles later.
- **Back-to-back:** store 0x41, 0x42, 0x43 on consecutive cycles → three frames with no idle gap (30·`CLKS_PER_BIT` cycles); decoded string "ABC".
- **Overflow:** with the FSM mid-frame, perform 9 stores with `FIFO_DEPTH`=8 → STATUS shows full=1, ovf=1, count=8. The 9th byte is never transmitted. Writing STATUS with 0x8 clears ovf.
- **Full with simultaneous pop:** push in the exact cycle STOP ends with FIFO full → byte accepted, ovf stays 0, count stays 8.
- **Decode window:** store to `BASE_ADDR`+8 and load from `BASE_ADDR`-4 → no push, `rdata`=0. Load from `BASE_ADDR`+4 returns count in bits[15:8].
